ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter.
- Sends one command byte to the mouse over the bidirectional PS2Clk/PS2Data lines, e.g. 0xF4 enable data reporting or 0xFF reset.
- Counterpart of the existing PS/2 receive path. Sits beside the mouse receiver inside the memory/logic top and shares the same open-drain pins.
- Drives the lines through pull-low enables only. The pin-level tristate lives at the top.

Parameters:
- INHIBIT_CYCLES, 12000: clk periods PS2Clk is held low before the request (120 us at 100 MHz).
- REQ_CYCLES, 200: clk periods both lines are held low before PS2Clk is released.
- TIMEOUT_CYCLES, 2000000: maximum clk periods allowed between consecutive device falling edges, or before the first one (20 ms).

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte; captured on an accepted tx_start.
- tx_start  in  1  single-cycle request; accepted only when tx_busy=0.
- ps2_clk_in  in  1  raw PS2Clk pin level (asynchronous).
- ps2_data_in  in  1  raw PS2Data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2Clk low, 0 = release.
- ps2_data_oe  out  1  1 = pull PS2Data low, 0 = release.
- tx_busy  out  1  transfer in progress; the receiver ignores edges while this is high.
- tx_done  out  1  one-cycle pulse: byte acknowledged and bus idle.
- tx_nack  out  1  one-cycle pulse: ack bit sampled high.
- tx_timeout  out  1  one-cycle pulse: watchdog expired.

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in IDLE, counters cleared. Lines are released immediately, including when reset is asserted mid-transfer.
- Input conditioning: 2-flop synchronisers on both pins. fall = clk_sync_q & ~clk_sync. All decisions use the synchronised values.
- Frame: shift register loaded at accept with {stop=1, parity=~^tx_data (odd), tx_data}, sent LSB first.
- IDLE: tx_start=1 -> latch the frame, bit_idx=0, go to INHIBIT. tx_busy=1 from the next cycle. tx_start while busy is ignored, with no queueing.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES, then go to REQ.
- REQ: clk_oe=1 and data_oe=1 (start bit) for REQ_CYCLES, then go to SEND. Release clk_oe and clear the watchdog.
- SEND: clk_oe=0. On each fall, data_oe <= ~frame[bit_idx] and bit_idx++. Falls 1..8 drive D0..D7, fall 9 drives parity, fall 10 drives stop (data_oe=0). Then go to ACK.
- ACK: on the next fall, sample data_sync. A value of 0 goes to WAIT_IDLE. A value of 1 pulses tx_nack and goes to IDLE.
- WAIT_IDLE: when clk_sync=1 and data_sync=1 in the same cycle, pulse tx_done and go to IDLE.
- tx_busy: high in INHIBIT, REQ, SEND, ACK and WAIT_IDLE. It drops in the same cycle the done, nack or timeout pulse is asserted.
- Watchdog: runs in SEND, ACK and WAIT_IDLE and clears on every fall. When it reaches TIMEOUT_CYCLES-1: release both lines, pulse tx_timeout, go to IDLE.
- Exclusivity: tx_done, tx_nack and tx_timeout are mutually exclusive. Watchdog expiry in the same cycle as a fall: the fall wins.
- Widths: counters are $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1) bits; bit_idx is 4 bits. Counters never wrap in any state.
- Outputs are registered; no combinational path from pins to outputs.

Decomposition:
- ps2_pkg:
  - typedef enum logic [2:0] ps2_tx_state_t {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE}.
  - Constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_RESP_ACK=8'hFA.
  - Function ps2_odd_parity.
- Sub-module ps2_sync_edge: 2-flop synchroniser plus falling-edge pulse. Instantiated twice (clk with edge detect, data level only); reusable by the receiver.

Test Plan:
Benches use INHIBIT_CYCLES=50, REQ_CYCLES=4, TIMEOUT_CYCLES=500; the device model clocks at 40-cycle half-period.
- Send 0xF4 with the device acking. Expect:
  - clk_oe high for exactly 50 cycles, then 4 cycles with both oe high.
  - Device samples 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - tx_done is a single pulse after lines go high.
- Send 0xFF -> sampled parity bit = 1; tx_done.
- Device holds data high in the ack slot -> tx_nack pulse, no tx_done, oe both 0.
- Device never clocks after REQ -> tx_timeout exactly 500 cycles after clk_oe release; lines released.
- Device stops after 4 bits -> tx_timeout 500 cycles after the last fall; a new tx_start is then accepted.
- Assert rst during SEND -> both oe 0 and tx_busy 0 asynchronously. tx_start 0x55 while busy -> ignored; only the first byte is seen by the device.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common mouse command bytes
// and the odd-parity helper used to build a frame.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_RESP_ACK   = 8'hFA;

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 pin with a one-cycle falling-edge pulse.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_q;

    // Flops reset to 1 so an idle (pulled-up) line never produces a spurious fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta   <= pin;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    assign level = sync;
    assign fall  = sync_q & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// shifts one command byte out on device clock edges, then checks the device ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_nack,
    output logic       tx_timeout
);

    localparam int MAX_A   = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > REQ_CYCLES) ? MAX_A : REQ_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk_in),
        .level (clk_sync),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_data_in),
        .level (data_sync),
        .fall  (data_fall_unused)
    );

    ps2_tx_state_t    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic [9:0]       frame;
    logic             clk_oe_n, data_oe_n, busy_n, done_n, nack_n, timeout_n;
    logic             accept;

    assign accept = (state == IDLE) && tx_start;

    // Frame is pure data, only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame <= {1'b1, ps2_odd_parity(tx_data), tx_data};
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        busy_n    = tx_busy;
        done_n    = 1'b0;
        nack_n    = 1'b0;
        timeout_n = 1'b0;

        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_n   = INHIBIT;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    clk_oe_n  = 1'b1;
                    data_oe_n = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    state_n   = REQ;
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REQ: begin
                if (cnt == REQ_LAST) begin
                    state_n  = SEND;
                    cnt_n    = '0;
                    clk_oe_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    data_oe_n = ~frame[bit_idx];
                    bit_idx_n = bit_idx + 4'd1;
                    cnt_n     = '0;
                    if (bit_idx == 4'd9) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    cnt_n = '0;
                    if (data_sync) begin
                        nack_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (clk_fall) begin
                    cnt_n = '0;
                end
            end
            default: begin
                state_n   = IDLE;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                busy_n    = 1'b0;
            end
        endcase

        // Watchdog: a device fall always takes priority over expiry.
        if ((state inside {SEND, ACK, WAIT_IDLE}) && !clk_fall && !done_n) begin
            if (cnt == TIMEOUT_LAST) begin
                state_n   = IDLE;
                cnt_n     = '0;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                busy_n    = 1'b0;
                timeout_n = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_nack     <= 1'b0;
            tx_timeout  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            tx_busy     <= busy_n;
            tx_done     <= done_n;
            tx_nack     <= nack_n;
            tx_timeout  <= timeout_n;
        end
    end

endmodule
